// File: rtl/mips32_run_pkg.sv
// Shared constants and state encoding for the MIPS32 run controller.
// Optional result checksum beat is enabled by defining MIPS32_RUN_CHKSUM_EN.
package mips32_run_pkg;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    localparam logic [5:0] OP_HLT = 6'h3f;

    typedef logic [2:0] run_state_t;

    localparam run_state_t ST_IDLE   = 3'd0;
    localparam run_state_t ST_LOAD   = 3'd1;
    localparam run_state_t ST_INIT   = 3'd2;
    localparam run_state_t ST_RUN    = 3'd3;
    localparam run_state_t ST_RDADDR = 3'd4;
    localparam run_state_t ST_RDWAIT = 3'd5;
    localparam run_state_t ST_REPORT = 3'd6;
    localparam run_state_t ST_DONE   = 3'd7;

endpackage

// File: rtl/mips32_run_cnt.sv
// Saturating run-cycle counter with synchronous clear and timeout-limit compare.
// hit_o flags the last permitted cycle so the FSM can exit on the same edge the count completes.
module mips32_run_cnt #(
    parameter int CNT_W = mips32_run_pkg::CNT_W
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] lim_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk1) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (lim_i != '0) && (cnt_q == (lim_i - CNT_W'(1)));

endmodule

// File: rtl/mips32_run_ctrl.sv
// Run controller: image load, core init/run with halt or timeout stop, result read-back stream.
// Define MIPS32_RUN_CHKSUM_EN to append a modular-sum beat after the last result word.
module mips32_run_ctrl #(
    parameter int ADDR_W = mips32_run_pkg::ADDR_W,
    parameter int DATA_W = 32,
    parameter int N_CHK  = 2,
    parameter int CNT_W  = mips32_run_pkg::CNT_W
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              start,
    input  logic [CNT_W-1:0]  timeout_lim,
    input  logic [ADDR_W-1:0] chk_base,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_init,
    output logic              core_run,
    input  logic              core_halted,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_idx,
    output logic              busy,
    output logic              done,
    output logic              timeout_flag,
    output logic [CNT_W-1:0]  cycle_cnt
);

    import mips32_run_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(N_CHK - 1);

    run_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [4:0]        idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tflag_q, tflag_d;
    logic              cnt_hit_s;
    logic              load_fire_s;
    logic              first_run_s;

`ifdef MIPS32_RUN_CHKSUM_EN
    localparam logic [4:0] CHK_IDX = 5'(N_CHK);
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    mips32_run_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk1  (clk1),
        .reset (reset),
        .clr_i (state_q == ST_INIT),
        .en_i  (state_q == ST_RUN),
        .lim_i (timeout_lim),
        .cnt_o (cycle_cnt),
        .hit_o (cnt_hit_s)
    );

    assign ld_ready     = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_LOAD);
    assign load_fire_s  = ld_ready && ld_valid;
    assign first_run_s  = (cycle_cnt == '0);

    assign mem_we       = load_fire_s;
    assign mem_wdata    = load_fire_s ? ld_data : '0;
    assign mem_addr     = load_fire_s ? ld_addr :
                          (state_q == ST_RDADDR) ? (base_q + ADDR_W'(idx_q)) : '0;

    assign core_init    = (state_q == ST_INIT);
    assign core_run     = (state_q == ST_RUN);
    assign res_valid    = (state_q == ST_REPORT);
    assign res_data     = rdata_q;
    assign res_idx      = idx_q;
    assign done         = (state_q == ST_DONE);
    assign busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign timeout_flag = tflag_q;

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        tflag_d = tflag_q;
`ifdef MIPS32_RUN_CHKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A load beat takes priority over a coincident start.
                if (ld_valid) begin
                    state_d = ld_last ? ST_IDLE : ST_LOAD;
                end else if (start) begin
                    state_d = ST_INIT;
                    base_d  = chk_base;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (ld_valid && ld_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_INIT: begin
                idx_d   = 5'd0;
                tflag_d = 1'b0;
`ifdef MIPS32_RUN_CHKSUM_EN
                sum_d   = '0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // The halt flag may still be stale from the previous run on the first cycle.
                if (core_halted && !first_run_s) begin
                    tflag_d = 1'b0;
                    state_d = ST_RDADDR;
                end else if (cnt_hit_s) begin
                    tflag_d = 1'b1;
                    state_d = ST_RDADDR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RDADDR: begin
                state_d = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                rdata_d = mem_rdata;
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) begin
`ifdef MIPS32_RUN_CHKSUM_EN
                    if (idx_q <= LAST_IDX) begin
                        sum_d = sum_q + rdata_q;
                    end else begin
                        sum_d = sum_q;
                    end
`endif
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_RDADDR;
`ifdef MIPS32_RUN_CHKSUM_EN
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = CHK_IDX;
                        rdata_d = sum_q + rdata_q;
                        state_d = ST_REPORT;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            idx_q   <= 5'd0;
            rdata_q <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            tflag_q <= tflag_d;
        end
    end

`ifdef MIPS32_RUN_CHKSUM_EN
    // Running sum of reported result words.
    always_ff @(posedge clk1) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Directed self-checking bench for mips32_run_ctrl with a behavioural memory and scripted core.
// Also covers the checksum beat when built with MIPS32_RUN_CHKSUM_EN.
module tb_mips32_run_ctrl;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_last;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        start;
    logic [15:0] timeout_lim;
    logic [9:0]  chk_base;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        core_init, core_run, core_halted;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_idx;
    logic        busy, done, timeout_flag;
    logic [15:0] cycle_cnt;

    logic        core_we;
    logic [9:0]  core_waddr;
    logic [31:0] core_wdata;
    logic [31:0] mem [1024];

    int n_assert = 0;
    int n_fail   = 0;

    mips32_run_ctrl dut (
        .clk1(clk1), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .start(start), .timeout_lim(timeout_lim), .chk_base(chk_base),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_init(core_init), .core_run(core_run), .core_halted(core_halted),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done), .timeout_flag(timeout_flag), .cycle_cnt(cycle_cnt)
    );

    always #5 clk1 = ~clk1;

    // Behavioural memory: controller and scripted core writes, registered read.
    always @(posedge clk1) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (core_we) mem[core_waddr] <= core_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic load_beat(input logic [9:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        #1;
        chk("ld_we", mem_we, 1);
        chk("ld_mem_addr", mem_addr, a);
        @(posedge clk1);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] lim, input logic [9:0] base);
        timeout_lim = lim; chk_base = base; start = 1'b1;
        step();
        start = 1'b0;
        chk("init_pulse", core_init, 1);
        chk("init_busy", busy, 1);
        step();
        chk("run_first", core_run, 1);
        chk("run_cnt0", cycle_cnt, 0);
        chk("run_noinit", core_init, 0);
    endtask

    // Entered in RDADDR; leaves one cycle after the REPORT handshake (res_ready high).
    task automatic word(input logic [9:0] a, input logic [31:0] d, input logic [4:0] idx);
        chk("rd_addr", mem_addr, a);
        chk("rd_we", mem_we, 0);
        step();
        step();
        chk("rep_valid", res_valid, 1);
        chk("rep_data", res_data, d);
        chk("rep_idx", res_idx, idx);
        step();
    endtask

    task automatic tail(input logic [31:0] sum);
`ifdef MIPS32_RUN_CHKSUM_EN
        chk("sum_valid", res_valid, 1);
        chk("sum_idx", res_idx, 2);
        chk("sum_data", res_data, sum);
        step();
`else
        chk("no_extra_beat", res_valid, 0);
`endif
        chk("done", done, 1);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; ld_valid = 1'b0; ld_addr = 10'd0; ld_data = 32'd0; ld_last = 1'b0;
        start = 1'b0; timeout_lim = 16'd0; chk_base = 10'd0; core_halted = 1'b0;
        res_ready = 1'b1; core_we = 1'b0; core_waddr = 10'd0; core_wdata = 32'd0;
        step();
        step();
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_run", core_run, 0);
        chk("rst_init", core_init, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_tflag", timeout_flag, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_res", {res_idx, res_data}, 0);
        reset = 1'b0;
        step();

        // Run 1: 9-beat image, core halts after 10 run cycles having stored 130 at 121.
        for (int i = 0; i < 8; i++) begin
            load_beat(10'(i), 32'h2000_0000 + 32'(i), 1'b0);
            chk("load_busy", busy, 1);
        end
        load_beat(10'd120, 32'd85, 1'b1);
        chk("load_end_busy", busy, 0);
        start_run(16'd200, 10'd120);
        repeat (9) step();
        chk("run1_cnt9", cycle_cnt, 9);
        core_halted = 1'b1; core_we = 1'b1; core_waddr = 10'd121; core_wdata = 32'd130;
        step();
        core_halted = 1'b0; core_we = 1'b0;
        chk("run1_stop", core_run, 0);
        chk("run1_cnt", cycle_cnt, 10);
        chk("run1_tflag", timeout_flag, 0);
        word(10'd120, 32'd85, 5'd0);
        word(10'd121, 32'd130, 5'd1);
        tail(32'd215);

        // Run 2: no halt, timeout after exactly 20 run cycles.
        load_beat(10'd0, 32'h0000_0020, 1'b0);
        load_beat(10'd1, 32'h0000_0021, 1'b1);
        start_run(16'd20, 10'd120);
        n = 0;
        while (core_run === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk("run2_run_cycles", n, 20);
        chk("run2_tflag", timeout_flag, 1);
        chk("run2_cnt", cycle_cnt, 20);
        word(10'd120, 32'd85, 5'd0);
        word(10'd121, 32'd130, 5'd1);
        tail(32'd215);
        chk("run2_tflag_held", timeout_flag, 1);

        // Run 3: halt already high on the first run cycle, consumer stalls for 5 cycles.
        res_ready = 1'b0;
        core_halted = 1'b1;
        start_run(16'd200, 10'd120);
        step();
        chk("run3_halt_ignored", core_run, 1);
        chk("run3_cnt1", cycle_cnt, 1);
        step();
        core_halted = 1'b0;
        chk("run3_stop", core_run, 0);
        chk("run3_tflag_clr", timeout_flag, 0);
        chk("run3_addr0", mem_addr, 120);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, 85);
            chk("stall_idx", res_idx, 0);
            step();
        end
        chk("stall_still_valid", res_valid, 1);
        res_ready = 1'b1;
        step();
        chk("stall_advance", res_valid, 0);
        word(10'd121, 32'd130, 5'd1);
        tail(32'd215);

        // Run 4: result base wraps from 1023 to 0.
        load_beat(10'd1023, 32'h0000_1111, 1'b0);
        load_beat(10'd0, 32'h0000_2222, 1'b1);
        start_run(16'd0, 10'd1023);
        step();
        core_halted = 1'b1;
        step();
        core_halted = 1'b0;
        chk("run4_stop", core_run, 0);
        chk("run4_cnt", cycle_cnt, 2);
        word(10'd1023, 32'h0000_1111, 5'd0);
        word(10'd0, 32'h0000_2222, 5'd1);
        tail(32'h0000_3333);

        // Run 5: reset at run cycle 7, then start ignored while loading.
        start_run(16'd0, 10'd120);
        repeat (7) step();
        chk("run5_cnt7", cycle_cnt, 7);
        reset = 1'b1;
        step();
        chk("midrst_run", core_run, 0);
        chk("midrst_ld_ready", ld_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", cycle_cnt, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        start = 1'b1;
        load_beat(10'd5, 32'h0000_0005, 1'b1);
        start = 1'b0;
        chk("ld_start_tie_init", core_init, 0);
        chk("ld_start_tie_busy", busy, 0);
        load_beat(10'd6, 32'h0000_0006, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_start_init", core_init, 0);
        chk("load_start_busy", busy, 1);
        chk("load_start_ready", ld_ready, 1);
        step();
        chk("load_start_run", core_run, 0);
        chk("load_start_init2", core_init, 0);
        load_beat(10'd7, 32'h0000_0007, 1'b1);
        chk("load_exit_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
